// File: rtl/ovl_fire_arbiter_pkg.sv
// Shared types and constants for the OVL fire arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package ovl_fire_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic KIND_2STATE = 1'b0;
    localparam logic KIND_XCHECK = 1'b1;

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin arbiter: rotate by ptr, pick the
// lowest set request, rotate the index back.
module ovl_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    always_comb begin
        rot       = '0;
        off       = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[wrap(int'(ptr) + k)];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_valid = 1'b1;
                off       = IW'(k);
            end
        end
        gnt_id = IW'(wrap(int'(off) + int'(ptr)));
    end

endmodule

// File: rtl/ovl_fire_arbiter.sv
// Captures OVL checker fire pulses as pending bits and serializes
// them into a valid/ready failure-report stream.
module ovl_fire_arbiter
    import ovl_fire_arbiter_pkg::*;
#(
    parameter int NUM_CHECKS = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int ID_WIDTH  = $clog2(NUM_CHECKS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CHECKS-1:0] fire_2state,
    input  logic [NUM_CHECKS-1:0] fire_xcheck,
    input  logic [NUM_CHECKS-1:0] mask,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [ID_WIDTH-1:0]   rpt_id,
    output logic                  rpt_kind,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  overflow,
    output logic                  busy
);

    state_t                state;
    logic [NUM_CHECKS-1:0] pend2;
    logic [NUM_CHECKS-1:0] pendx;
    logic [NUM_CHECKS-1:0] set2;
    logic [NUM_CHECKS-1:0] setx;
    logic [NUM_CHECKS-1:0] clr2;
    logic [NUM_CHECKS-1:0] clrx;
    logic [NUM_CHECKS-1:0] pend2_nxt;
    logic [NUM_CHECKS-1:0] pendx_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   ptr_nxt;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic                  gnt_valid;
    logic                  advance;
    logic                  load;
    logic                  kind_sel;
    logic                  ovf_hit;
    logic                  hs;
    logic                  valid_nxt;
    logic                  busy_nxt;

    // Arbiter sees only registered pending bits, never this cycle's fires.
    ovl_rr_arbiter #(
        .N(NUM_CHECKS)
    ) u_rr (
        .req      (pend2 | pendx),
        .ptr      (rr_ptr),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id)
    );

    always_comb begin
        set2     = fire_2state & ~mask & {NUM_CHECKS{enable}};
        setx     = fire_xcheck & ~mask & {NUM_CHECKS{enable}};
        hs       = rpt_valid & rpt_ready;
        advance  = (state == IDLE) | rpt_ready;
        load     = advance & gnt_valid;
        kind_sel = pend2[gnt_id] ? KIND_2STATE : KIND_XCHECK;
        clr2     = '0;
        clrx     = '0;
        if (load) begin
            if (kind_sel == KIND_2STATE) clr2[gnt_id] = 1'b1;
            else                         clrx[gnt_id] = 1'b1;
        end
        // Set wins over a same-cycle clear, so the new event stays queued.
        pend2_nxt = (pend2 & ~clr2) | set2;
        pendx_nxt = (pendx & ~clrx) | setx;
        ovf_hit   = (|(set2 & pend2 & ~clr2)) | (|(setx & pendx & ~clrx));
        valid_nxt = load | (rpt_valid & ~rpt_ready);
        busy_nxt  = valid_nxt | (|pend2_nxt) | (|pendx_nxt);
        ptr_nxt   = (gnt_id == ID_WIDTH'(NUM_CHECKS - 1)) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pend2      <= '0;
            pendx      <= '0;
            rr_ptr     <= '0;
            rpt_valid  <= 1'b0;
            rpt_id     <= '0;
            rpt_kind   <= KIND_2STATE;
            fail_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pend2 <= pend2_nxt;
            pendx <= pendx_nxt;
            busy  <= busy_nxt;
            if (ovf_hit) overflow <= 1'b1;
            if (hs && fail_count != '1) fail_count <= fail_count + 1'b1;
            if (load) begin
                rpt_id   <= gnt_id;
                rpt_kind <= kind_sel;
                rr_ptr   <= ptr_nxt;
            end
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= PRESENT;
                        rpt_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (rpt_ready && !load) begin
                        state     <= IDLE;
                        rpt_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rpt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ovl_fire_arbiter.sv
// Directed bench for ovl_fire_arbiter with hand-computed expectations.
// A second instance with a 4-bit counter covers saturation.
module tb_ovl_fire_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] fire2;
    logic [3:0] firex;
    logic [3:0] mask;
    logic       ready;

    logic        valid;
    logic [1:0]  id;
    logic        kind;
    logic [15:0] count;
    logic        ovf;
    logic        busy;

    logic        s_valid;
    logic [1:0]  s_id;
    logic        s_kind;
    logic [3:0]  s_count;
    logic        s_ovf;
    logic        s_busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ovl_fire_arbiter #(.NUM_CHECKS(4), .CNT_WIDTH(16)) dut (
        .clock(clk), .reset(rst), .enable(enable),
        .fire_2state(fire2), .fire_xcheck(firex), .mask(mask),
        .rpt_valid(valid), .rpt_ready(ready), .rpt_id(id),
        .rpt_kind(kind), .fail_count(count), .overflow(ovf),
        .busy(busy)
    );

    ovl_fire_arbiter #(.NUM_CHECKS(4), .CNT_WIDTH(4)) dut_sat (
        .clock(clk), .reset(rst), .enable(enable),
        .fire_2state(fire2), .fire_xcheck(firex), .mask(mask),
        .rpt_valid(s_valid), .rpt_ready(ready), .rpt_id(s_id),
        .rpt_kind(s_kind), .fail_count(s_count), .overflow(s_ovf),
        .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        fire2 = '0;
        firex = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_ids[4];
        rst    = 1'b1;
        enable = 1'b1;
        fire2  = '0;
        firex  = '0;
        mask   = '0;
        ready  = 1'b0;
        tick();

        // reset values
        do_reset();
        ready = 1'b1;
        check("rst_valid", 32'(valid), 0);
        check("rst_id", 32'(id), 0);
        check("rst_kind", 32'(kind), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);

        // single fire on checker 2
        tick();
        fire2 = 4'b0100;
        tick();
        fire2 = '0;
        check("single_pend_valid", 32'(valid), 0);
        check("single_pend_busy", 32'(busy), 1);
        tick();
        check("single_valid", 32'(valid), 1);
        check("single_id", 32'(id), 2);
        check("single_kind", 32'(kind), 0);
        tick();
        check("single_done_valid", 32'(valid), 0);
        check("single_count", 32'(count), 1);
        check("single_busy", 32'(busy), 0);

        // fairness from rr_ptr 0
        do_reset();
        ready = 1'b1;
        fire2 = 4'hF;
        tick();
        fire2 = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr0_valid", 32'(valid), 1);
            check("rr0_id", 32'(id), 32'(k));
        end
        tick();
        check("rr0_idle", 32'(valid), 0);
        check("rr0_count", 32'(count), 4);

        // fairness from rr_ptr 2 (after granting checker 1)
        do_reset();
        ready = 1'b1;
        fire2 = 4'b0010;
        tick();
        fire2 = '0;
        tick();
        check("rr2_pre_id", 32'(id), 1);
        tick();
        fire2 = 4'hF;
        tick();
        fire2 = '0;
        exp_ids = '{2, 3, 0, 1};
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr2_valid", 32'(valid), 1);
            check("rr2_id", 32'(id), 32'(exp_ids[k]));
        end
        tick();
        check("rr2_idle", 32'(valid), 0);
        check("rr2_count", 32'(count), 5);

        // kind priority within one checker
        do_reset();
        ready = 1'b1;
        fire2 = 4'b0010;
        firex = 4'b0010;
        tick();
        fire2 = '0;
        firex = '0;
        tick();
        check("kind_a_id", 32'(id), 1);
        check("kind_a_kind", 32'(kind), 0);
        tick();
        check("kind_b_valid", 32'(valid), 1);
        check("kind_b_id", 32'(id), 1);
        check("kind_b_kind", 32'(kind), 1);
        tick();
        check("kind_idle", 32'(valid), 0);
        check("kind_count", 32'(count), 2);

        // backpressure and coalescing on checker 0
        do_reset();
        ready = 1'b0;
        fire2 = 4'b0001;
        tick();
        fire2 = '0;
        tick();
        check("bp_valid", 32'(valid), 1);
        check("bp_id", 32'(id), 0);
        fire2 = 4'b0001;
        tick();
        fire2 = '0;
        check("bp_ovf_early", 32'(ovf), 0);
        check("bp_hold1", 32'(valid), 1);
        fire2 = 4'b0001;
        tick();
        fire2 = '0;
        check("bp_ovf", 32'(ovf), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_hold_valid", 32'(valid), 1);
            check("bp_hold_id", 32'(id), 0);
            check("bp_hold_count", 32'(count), 0);
        end
        ready = 1'b1;
        tick();
        check("bp_extra_valid", 32'(valid), 1);
        check("bp_extra_id", 32'(id), 0);
        check("bp_extra_count", 32'(count), 1);
        tick();
        check("bp_end_valid", 32'(valid), 0);
        check("bp_end_count", 32'(count), 2);
        tick();
        check("bp_no_more", 32'(valid), 0);
        check("bp_busy", 32'(busy), 0);
        check("bp_ovf_sticky", 32'(ovf), 1);

        // mask gating
        do_reset();
        ready = 1'b1;
        mask  = 4'b1000;
        fire2 = 4'b1000;
        tick();
        fire2 = '0;
        tick();
        tick();
        check("mask_valid", 32'(valid), 0);
        check("mask_busy", 32'(busy), 0);
        mask = '0;

        // mask raised on an already pending bit still drains
        fire2 = 4'b0100;
        tick();
        fire2 = '0;
        mask  = 4'b0100;
        tick();
        check("mask_drain_valid", 32'(valid), 1);
        check("mask_drain_id", 32'(id), 2);
        tick();
        check("mask_drain_end", 32'(valid), 0);
        mask = '0;

        // enable low stops captures but pending drains
        fire2 = 4'b0010;
        tick();
        enable = 1'b0;
        fire2  = 4'hF;
        firex  = 4'hF;
        tick();
        check("en_drain_valid", 32'(valid), 1);
        check("en_drain_id", 32'(id), 1);
        tick();
        check("en_no_capture", 32'(valid), 0);
        fire2  = '0;
        firex  = '0;
        enable = 1'b1;
        tick();
        check("en_busy", 32'(busy), 0);
        check("en_count", 32'(count), 2);
        check("en_ovf", 32'(ovf), 0);

        // saturation: 20 accepted reports
        do_reset();
        ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            fire2 = 4'hF;
            tick();
            fire2 = '0;
            repeat (5) tick();
        end
        check("sat_count16", 32'(count), 20);
        check("sat_count4", 32'(s_count), 15);

        // reset while a report is held
        ready = 1'b0;
        fire2 = 4'b0110;
        tick();
        fire2 = 4'b0100;
        tick();
        fire2 = '0;
        check("hold_valid", 32'(valid), 1);
        check("hold_id", 32'(id), 1);
        check("hold_ovf", 32'(ovf), 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_id", 32'(id), 0);
        check("mid_rst_kind", 32'(kind), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_count4", 32'(s_count), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_busy", 32'(busy), 0);
        ready = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(valid), 0);
        check("post_rst_count", 32'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ovl_fire_arbiter.md
# ovl_fire_arbiter

Collects fire pulses from up to NUM_CHECKS OVL checker instances and turns them into a serialized failure-report stream. Each event is held as a pending bit per checker and kind. A round-robin arbiter presents one report at a time on a valid/ready handshake to the shared error-reporting/logging sink. The block also keeps a saturating failure counter and a sticky lost-event flag, and sits between the checker array and the single report consumer.

## Interface
- NUM_CHECKS, 4, number of checker instances served (2..32)
- CNT_WIDTH, 16, width of fail_count
- ID_WIDTH, $clog2(NUM_CHECKS), width of rpt_id (derived, not overridden)
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  when low, new fires are not captured; queued reports still drain
- fire_2state  in  NUM_CHECKS  per-checker 2-state assertion-failure pulse
- fire_xcheck  in  NUM_CHECKS  per-checker X/Z-detect failure pulse
- mask  in  NUM_CHECKS  per-checker ignore (OVL_IGNORE property type); blocks new captures only
- rpt_valid  out  1  report present
- rpt_ready  in  1  sink accepts report
- rpt_id  out  ID_WIDTH  index of the reporting checker
- rpt_kind  out  1  0 = 2-state failure, 1 = X/Z failure
- fail_count  out  CNT_WIDTH  accepted reports, saturating
- overflow  out  1  sticky; an event was coalesced into an already-pending bit
- busy  out  1  rpt_valid or any pending bit set

## Operation
- Pending storage: pend2[i] and pendx[i] per checker.
  - Set when fire_*[i] & enable & ~mask[i].
  - Cleared when that bit is loaded into the report register.
  - Set and clear in the same cycle: set wins, and the new event stays pending.
  - Fire on a bit that is already set and not being cleared that cycle: bit stays set, overflow <= 1.
- Arbitration over checkers:
  - Round-robin, starting at pointer rr_ptr.
  - A checker is eligible if pend2 | pendx.
  - Within a checker, pend2 has priority over pendx.
  - After a grant, rr_ptr <= granted_id + 1, wrapping NUM_CHECKS-1 -> 0.
- FSM states:
  - IDLE: rpt_valid = 0. If any pending bit is set, load rpt_id/rpt_kind from the arbiter, clear the granted bit, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: rpt_valid = 1. rpt_id and rpt_kind are held stable until rpt_ready.
    - On handshake (rpt_valid & rpt_ready), fail_count <= fail_count + 1, saturating at all-ones.
    - On handshake with a pending bit still set: load the next grant in the same cycle and stay in PRESENT (back-to-back).
    - On handshake with nothing pending: go to IDLE.
- Arbiter input:
  - Pending bits as registered, excluding any bit being set this cycle.
  - Events never bypass the pending register.
- mask asserted while a bit is pending: the bit still drains.
- enable low: captures stop; arbitration, handshake and counting continue.
- Reset mid-report: rpt_valid drops the next cycle. All pending bits and the report are discarded and are not counted.

## Timing
- Reset values: rpt_valid 0, rpt_id 0, rpt_kind 0, fail_count 0, overflow 0, busy 0, rr_ptr 0, FSM IDLE, all pending bits 0.
- Latency from fire in cycle t:
  - Pending bit set at edge t+1.
  - Report loaded at edge t+2, so rpt_valid is high during cycle t+2 when the FSM was IDLE.
- Throughput: one report per cycle while rpt_ready is held high and events are pending.
- rpt_valid never drops without a handshake, except on reset.
- All outputs are registered. No combinational path from rpt_ready to rpt_valid, rpt_id or rpt_kind.

## Structure
- Package ovl_fire_arbiter_pkg:
  - state_t enum {IDLE, PRESENT}.
  - kind constants KIND_2STATE = 1'b0, KIND_XCHECK = 1'b1.
- Sub-module ovl_rr_arbiter (parameter N):
  - Inputs: req[N], ptr.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational rotate / priority-encode / rotate-back.
- The top level holds the pending registers, FSM, counter and flags.

## Test plan
- Single fire: fire_2state[2] pulse at cycle 5, rpt_ready = 1. Required: rpt_valid in cycle 7 with rpt_id = 2, rpt_kind = 0; fail_count = 1 after the handshake; busy = 0 in cycle 8.
- Fairness and back-to-back: all four fire_2state bits pulse together, rpt_ready = 1. Required: ids reported 0, 1, 2, 3 in consecutive cycles; fail_count = 4.
  - Repeat with rr_ptr = 2. Required order: 2, 3, 0, 1.
- Kind priority: fire_2state[1] and fire_xcheck[1] in the same cycle. Required: (1, kind 0) first, then (1, kind 1).
- Backpressure and coalescing: rpt_ready = 0 for 10 cycles while fire_2state[0] pulses at cycles 5 and 8. Required: report held stable throughout; overflow = 1; exactly one extra report for checker 0 after release.
- Gating: mask[3] = 1 with fire_2state[3] -> no report. enable = 0 with any fire -> no report, while an already pending report still drains.
- Saturation and reset: CNT_WIDTH = 4 with 20 accepted reports -> fail_count = 15. reset asserted in cycle 3 of a held report -> all outputs at reset values on the next edge.
